// File: rtl/serial_addsub_pkg.sv
// Shared types for the bit-serial adder/subtractor.
// FSM state encoding and the slice counter width helper.
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/serial_addsub_slice.sv
// Combinational BPC-bit ripple of full-adder cells.
// c_msb is the carry into the top bit, used for overflow.
module addsub_slice #(
  parameter int BPC = 1
) (
  input  logic [BPC-1:0] x,
  input  logic [BPC-1:0] y,
  input  logic           ci,
  output logic [BPC-1:0] sum,
  output logic           co,
  output logic           c_msb
);

  logic [BPC:0] c;

  always_comb begin
    c     = '0;
    sum   = '0;
    c[0]  = ci;
    for (int i = 0; i < BPC; i++) begin
      sum[i]  = x[i] ^ y[i] ^ c[i];
      c[i+1]  = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
    co    = c[BPC];
    c_msb = c[BPC-1];
  end

endmodule

// File: rtl/serial_addsub.sv
// Multi-cycle adder/subtractor, BPC bits per clock, LSB first.
// start/ready/done handshake; results registered on DONE entry.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int BPC   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             done
);

  localparam int N  = WIDTH / BPC;
  localparam int CW = cnt_width(N);

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_q, b_q, sum_q, sum_nx;
  logic [WIDTH-1:0] s_q;
  logic [CW-1:0]    cnt_q;
  logic             c_q, cout_q, ovf_q;
  logic             accept, last;

  logic [BPC-1:0]   sl_sum;
  logic             sl_co, sl_cm;

  addsub_slice #(.BPC(BPC)) u_slice (
    .x     (a_q[BPC-1:0]),
    .y     (b_q[BPC-1:0]),
    .ci    (c_q),
    .sum   (sl_sum),
    .co    (sl_co),
    .c_msb (sl_cm)
  );

  // slice result enters from the MSB end
  assign sum_nx = (sum_q >> BPC)
                | (WIDTH'(sl_sum) << (WIDTH - BPC));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    last    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (cnt_q == CW'(N - 1)) begin
          last    = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      sum_q  <= '0;
      c_q    <= 1'b0;
      cnt_q  <= '0;
      s_q    <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (accept) begin
      a_q   <= a;
      b_q   <= sub ? ~b : b;
      c_q   <= cin ^ sub;
      cnt_q <= '0;
      sum_q <= '0;
    end else if (state_q == RUN) begin
      a_q   <= a_q >> BPC;
      b_q   <= b_q >> BPC;
      sum_q <= sum_nx;
      c_q   <= sl_co;
      cnt_q <= cnt_q + 1'b1;
      if (last) begin
        s_q    <= sum_nx;
        cout_q <= sl_co;
        ovf_q  <= sl_co ^ sl_cm;
      end
    end
  end

  assign ready = (state_q == IDLE);
  assign done  = (state_q == DONE);
  assign s     = s_q;
  assign cout  = cout_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: directed table, handshake corners,
// random 8-bit ops and exhaustive 4-bit ops vs. an arithmetic model.
module tb_serial_addsub;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start8 = 0, cin8 = 0, sub8 = 0;
  logic [7:0] a8 = 0, b8 = 0;
  logic       ready8, cout8, ovf8, done8;
  logic [7:0] s8;

  logic       start4 = 0, cin4 = 0, sub4 = 0;
  logic [3:0] a4 = 0, b4 = 0;
  logic       rdy_p, co_p, ov_p, dn_p;
  logic       rdy_q, co_q, ov_q, dn_q;
  logic [3:0] s_p, s_q;

  serial_addsub #(.WIDTH(8), .BPC(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .ready(ready8),
    .a(a8), .b(b8), .cin(cin8), .sub(sub8),
    .s(s8), .cout(cout8), .ovf(ovf8), .done(done8)
  );

  serial_addsub #(.WIDTH(4), .BPC(4)) dut4p (
    .clk(clk), .rst_n(rst_n), .start(start4), .ready(rdy_p),
    .a(a4), .b(b4), .cin(cin4), .sub(sub4),
    .s(s_p), .cout(co_p), .ovf(ov_p), .done(dn_p)
  );

  serial_addsub #(.WIDTH(4), .BPC(2)) dut4q (
    .clk(clk), .rst_n(rst_n), .start(start4), .ready(rdy_q),
    .a(a4), .b(b4), .cin(cin4), .sub(sub4),
    .s(s_q), .cout(co_q), .ovf(ov_q), .done(dn_q)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input longint act,
                     input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views
  task automatic model(input int w, input longint ia, ib,
                       input int ic, isb,
                       output longint es, output int ec, eo);
    longint mask, full, sa, sb, sv, hi, lo;
    mask = (longint'(1) << w) - 1;
    hi   = (longint'(1) << (w - 1)) - 1;
    lo   = -(longint'(1) << (w - 1));
    sa   = (ia > hi) ? ia - (mask + 1) : ia;
    sb   = (ib > hi) ? ib - (mask + 1) : ib;
    if (isb == 0) begin
      full = ia + ib + ic;
      sv   = sa + sb + ic;
    end else begin
      full = ia + (~ib & mask) + (1 - ic);
      sv   = sa - sb - ic;
    end
    es = full & mask;
    ec = int'((full >> w) & 1);
    eo = (sv > hi || sv < lo) ? 1 : 0;
  endtask

  // Issues one op on the 8-bit DUT (must be IDLE); returns in IDLE
  task automatic run8(input string nm, input logic [7:0] ia, ib,
                      input logic ic, isb,
                      input logic [7:0] es, input logic ec, eo);
    logic [7:0] prev;
    int lat;
    bit hold_ok;
    prev   = s8;
    a8     = ia;
    b8     = ib;
    cin8   = ic;
    sub8   = isb;
    start8 = 1'b1;
    step();
    start8 = 1'b0;
    a8     = 8'($urandom);
    b8     = 8'($urandom);
    cin8   = 1'($urandom);
    sub8   = 1'($urandom);
    lat     = -1;
    hold_ok = 1;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (done8) begin
        lat = k;
        break;
      end
      if (s8 !== prev) hold_ok = 0;
    end
    chk({nm, ".latency"}, lat, 8);
    chk({nm, ".hold"}, hold_ok, 1);
    chk({nm, ".s"}, s8, es);
    chk({nm, ".cout"}, cout8, ec);
    chk({nm, ".ovf"}, ovf8, eo);
    step();
    chk({nm, ".done_pulse"}, {done8, ready8}, 2'b01);
    chk({nm, ".s_held"}, s8, es);
  endtask

  typedef struct {
    logic [7:0] a, b;
    logic       cin, sub;
    logic [7:0] s;
    logic       cout, ovf;
  } vec_t;

  vec_t tbl[6];

  initial begin
    longint es;
    int     ec, eo, lat, lat_p, lat_q;
    logic [3:0] cs_p, cs_q;
    logic   cc_p, cc_q, co_vp, co_vq;
    bit     seen;

    tbl[0] = '{8'h0F, 8'h01, 0, 0, 8'h10, 0, 0};
    tbl[1] = '{8'hFF, 8'h01, 0, 0, 8'h00, 1, 0};
    tbl[2] = '{8'h7F, 8'h01, 0, 0, 8'h80, 0, 1};
    tbl[3] = '{8'h05, 8'h07, 0, 1, 8'hFE, 0, 0};
    tbl[4] = '{8'h05, 8'h07, 1, 1, 8'hFD, 0, 0};
    tbl[5] = '{8'h80, 8'h01, 0, 1, 8'h7F, 1, 1};

    // reset
    rst_n = 1'b0;
    step();
    step();
    chk("rst.ready", ready8, 1);
    chk("rst.done", done8, 0);
    chk("rst.s", s8, 0);
    chk("rst.cout", cout8, 0);
    chk("rst.ovf", ovf8, 0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 6; i++)
      run8($sformatf("vec%0d", i), tbl[i].a, tbl[i].b,
           tbl[i].cin, tbl[i].sub, tbl[i].s, tbl[i].cout,
           tbl[i].ovf);

    // reset mid-RUN: outputs clear at once, no done follows
    a8 = 8'h12; b8 = 8'h34; cin8 = 0; sub8 = 0; start8 = 1;
    step();
    start8 = 0;
    step();
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst.ready", ready8, 1);
    chk("midrst.done", done8, 0);
    chk("midrst.s", s8, 0);
    chk("midrst.cout", cout8, 0);
    chk("midrst.ovf", ovf8, 0);
    step();
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (done8) seen = 1;
    end
    chk("midrst.no_done", seen, 0);

    // start pulsed while busy is ignored
    a8 = 8'h10; b8 = 8'h20; cin8 = 0; sub8 = 0; start8 = 1;
    step();
    start8 = 0;
    step();
    step();
    chk("busy.ready", ready8, 0);
    a8 = 8'h33; start8 = 1;
    step();
    start8 = 0;
    lat = -1;
    for (int k = 4; k <= 40; k++) begin
      step();
      if (done8) begin
        lat = k;
        break;
      end
    end
    chk("busy.latency", lat, 8);
    chk("busy.s", s8, 8'h30);
    step();
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (done8) seen = 1;
    end
    chk("busy.not_queued", seen, 0);

    // start held high: back-to-back ops every N+2 clocks
    a8 = 8'h21; b8 = 8'h03; cin8 = 1; sub8 = 0; start8 = 1;
    step();
    a8 = 8'h40; b8 = 8'h41; cin8 = 0; sub8 = 1;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (done8) begin
        lat = k;
        break;
      end
    end
    chk("b2b.first_lat", lat, 8);
    chk("b2b.first_s", s8, 8'h25);
    step();
    chk("b2b.idle", ready8, 1);
    step();
    start8 = 0;
    chk("b2b.accepted", ready8, 0);
    lat = -1;
    for (int k = 3; k <= 40; k++) begin
      step();
      if (done8) begin
        lat = k;
        break;
      end
    end
    chk("b2b.period", lat, 10);
    chk("b2b.second_s", s8, 8'hFF);
    chk("b2b.second_cout", cout8, 0);
    step();

    // random 8-bit ops vs model
    for (int i = 0; i < 40; i++) begin
      logic [7:0] ra, rb;
      logic rc, rs;
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      rs = 1'($urandom);
      model(8, longint'(ra), longint'(rb), int'(rc), int'(rs),
            es, ec, eo);
      run8($sformatf("rnd%0d", i), ra, rb, rc, rs, 8'(es),
           1'(ec), 1'(eo));
    end

    // exhaustive 4-bit on BPC=4 and BPC=2
    for (int ia = 0; ia < 16; ia++)
      for (int ib = 0; ib < 16; ib++)
        for (int m = 0; m < 4; m++) begin
          a4 = 4'(ia); b4 = 4'(ib);
          cin4 = m[0]; sub4 = m[1];
          start4 = 1;
          step();
          start4 = 0;
          a4 = 4'($urandom); b4 = 4'($urandom);
          lat_p = -1; lat_q = -1;
          cs_p = 0; cs_q = 0;
          cc_p = 0; cc_q = 0; co_vp = 0; co_vq = 0;
          for (int k = 1; k <= 6; k++) begin
            step();
            if (dn_p && lat_p < 0) begin
              lat_p = k; cs_p = s_p; cc_p = co_p; co_vp = ov_p;
            end
            if (dn_q && lat_q < 0) begin
              lat_q = k; cs_q = s_q; cc_q = co_q; co_vq = ov_q;
            end
          end
          model(4, longint'(ia), longint'(ib), int'(m[0]),
                int'(m[1]), es, ec, eo);
          chk("w4b4.lat", lat_p, 1);
          chk("w4b4.s", cs_p, es);
          chk("w4b4.cout", cc_p, ec);
          chk("w4b4.ovf", co_vp, eo);
          chk("w4b2.lat", lat_q, 2);
          chk("w4b2.s", cs_q, es);
          chk("w4b2.cout", cc_q, ec);
          chk("w4b2.ovf", co_vq, eo);
        end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
